// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised RO_IN rising edges over a GATE_LEN-cycle window.
// Result (COUNT/OVF) valid with DONE, GATE_LEN+7 cycles after START (1 cycle for GATE_LEN=0); START ignored while not idle.
module ro_freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [GATE_W-1:0] GATE_LEN,
    input  logic              RO_IN,
    output logic              RO_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_GATE   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    // Timer values are "cycles remaining minus one" for each phase.
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(3);
    localparam logic [GATE_W-1:0] DRAIN_LAST  = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GATE_W-1:0]   r_timer;
    logic [GATE_W-1:0]   r_gate_len;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_acc;
    logic                r_ro_en;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;

    logic                w_timer_zero;
    logic                w_rise;
    logic                w_start_meas;
    logic                w_nxt_osc;

    assign w_timer_zero = (r_timer == '0);
    assign w_rise       = r_sync2 & ~r_sync3;
    assign w_start_meas = (r_state == S_IDLE) && START && (GATE_LEN != '0);
    assign w_nxt_osc    = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_GATE);

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= RO_IN;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = (GATE_LEN == '0) ? S_FIN : S_SETTLE;
                end
            end
            S_SETTLE: if (w_timer_zero) w_state_nxt = S_GATE;
            S_GATE:   if (w_timer_zero) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_timer_zero) w_state_nxt = S_FIN;
            S_FIN:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Phase timer; the gate length is latched so later GATE_LEN changes are harmless.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_timer    <= '0;
            r_gate_len <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_meas) begin
                        r_timer    <= SETTLE_LAST;
                        r_gate_len <= GATE_LEN;
                    end
                end
                S_SETTLE: r_timer <= w_timer_zero ? (r_gate_len - GATE_W'(1)) : (r_timer - GATE_W'(1));
                S_GATE:   r_timer <= w_timer_zero ? DRAIN_LAST : (r_timer - GATE_W'(1));
                S_DRAIN:  r_timer <= w_timer_zero ? '0 : (r_timer - GATE_W'(1));
                default:  r_timer <= '0;
            endcase
        end
    end

    // Saturating edge counter; an edge that cannot be counted flags overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (w_start_meas) begin
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if ((r_state == S_GATE) && w_rise) begin
            if (r_cnt == CNT_MAX) begin
                r_ovf_acc <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs registered from the next state so they change cleanly at the same edge as the FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ro_en <= w_nxt_osc;
            r_busy  <= w_nxt_osc || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_FIN);
            if (w_state_nxt == S_FIN) begin
                // Zero-length gate goes straight from IDLE and reports an empty result.
                r_count <= (r_state == S_IDLE) ? '0 : r_cnt;
                r_ovf   <= (r_state == S_IDLE) ? 1'b0 : r_ovf_acc;
            end
        end
    end

    assign RO_EN = r_ro_en;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: scoreboard queues filled at START, drained when DONE is observed.
module tb_ro_freq_meter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        START4;
    logic [15:0] GATE_LEN;
    logic [15:0] GATE_LEN4;
    logic        RO_IN;
    logic        RO_EN, BUSY, DONE, OVF;
    logic [15:0] COUNT;
    logic        RO_EN4, BUSY4, DONE4, OVF4;
    logic [3:0]  COUNT4;

    ro_freq_meter dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .GATE_LEN(GATE_LEN), .RO_IN(RO_IN),
        .RO_EN(RO_EN), .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT), .OVF(OVF)
    );

    ro_freq_meter #(.GATE_W(16), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .START(START4), .GATE_LEN(GATE_LEN4), .RO_IN(RO_IN),
        .RO_EN(RO_EN4), .BUSY(BUSY4), .DONE(DONE4), .COUNT(COUNT4), .OVF(OVF4)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Free-running oscillator model; half period in ns (clock period is 10 ns), 0 = held low.
    int ro_half = 0;
    initial begin
        RO_IN = 1'b0;
        forever begin
            if (ro_half == 0) begin
                RO_IN = 1'b0;
                #1;
            end else begin
                RO_IN = 1'b1;
                #(ro_half);
                RO_IN = 1'b0;
                #(ro_half);
            end
        end
    end

    typedef struct {
        int cnt;
        int tol;
        bit ovf;
        int at;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ro_cnt, busy_cnt, done_cnt, done4_cnt;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input longint obs, input longint lo, input longint hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One clock; observe outputs on the falling edge and retire scoreboard entries on DONE.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (RO_EN) ro_cnt++;
        if (BUSY)  busy_cnt++;
        if (DONE) begin
            done_cnt++;
            if (q.size() == 0) begin
                check("done_without_request", q.size(), 1);
            end else begin
                e = q.pop_front();
                check_rng("count", COUNT, e.cnt - e.tol, e.cnt + e.tol);
                check("ovf", OVF, e.ovf);
                check("done_cycle", cyc, e.at);
            end
        end
        if (DONE4) begin
            done4_cnt++;
            if (q4.size() == 0) begin
                check("done4_without_request", q4.size(), 1);
            end else begin
                e = q4.pop_front();
                check_rng("count4", COUNT4, e.cnt - e.tol, e.cnt + e.tol);
                check("ovf4", OVF4, e.ovf);
                check("done4_cycle", cyc, e.at);
            end
        end
    endtask

    // Call right after tick(). DONE is expected gl+6 edges after the sampling edge (0 for gl=0).
    task automatic start_run(input bit sel, input int gl, input int ec, input int tol,
                             input bit eo, input bit hold);
        exp_t e;
        if (!sel) begin
            GATE_LEN = 16'(gl);
            START    = 1'b1;
        end else begin
            GATE_LEN4 = 16'(gl);
            START4    = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (!hold) begin
            START  = 1'b0;
            START4 = 1'b0;
        end
        e.cnt = ec;
        e.tol = tol;
        e.ovf = eo;
        e.at  = cyc + ((gl == 0) ? 0 : gl + 6);
        if (!sel) q.push_back(e);
        else      q4.push_back(e);
        ro_cnt   = 0;
        busy_cnt = 0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int d0;
        d0 = sel ? done4_cnt : done_cnt;
        for (int i = 0; i < budget; i++) begin
            if ((sel ? done4_cnt : done_cnt) != d0) break;
            tick();
        end
        check(sel ? "done4_within_budget" : "done_within_budget",
              (sel ? done4_cnt : done_cnt) - d0, 1);
    endtask

    initial begin
        int d0;
        int held_bad;
        START = 1'b0; START4 = 1'b0; GATE_LEN = '0; GATE_LEN4 = '0;
        done_cnt = 0; done4_cnt = 0; ro_cnt = 0; busy_cnt = 0;
        RST_N = 1'b0;
        #12;
        check("rst_ro_en", RO_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_count", COUNT, 0);
        check("rst_ovf", OVF, 0);
        check("rst_count4", COUNT4, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) tick();

        // Oscillator period 10 clocks, 100-cycle gate.
        ro_half = 50;
        repeat (20) tick();
        start_run(0, 100, 10, 1, 0, 0);
        wait_done(0, 200);
        check("ro_en_cycles_100", ro_cnt, 104);
        check("busy_cycles_100", busy_cnt, 106);
        tick();
        check("done_width_100", DONE, 0);

        // Asynchronous reset in the middle of the gate aborts the run.
        start_run(0, 50, 5, 1, 0, 0);
        repeat (20) tick();
        #2 RST_N = 1'b0;
        #1;
        check("abort_ro_en", RO_EN, 0);
        check("abort_busy", BUSY, 0);
        check("abort_count", COUNT, 0);
        check("abort_ovf", OVF, 0);
        q.delete();
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        d0 = done_cnt;
        repeat (60) tick();
        check("no_done_after_abort", done_cnt - d0, 0);
        start_run(0, 20, 2, 1, 0, 0);
        wait_done(0, 60);
        check("ro_en_cycles_after_abort", ro_cnt, 24);

        // Oscillator held low, 20-cycle gate.
        ro_half = 0;
        repeat (30) tick();
        start_run(0, 20, 0, 0, 0, 0);
        wait_done(0, 60);
        check("busy_cycles_20", busy_cnt, 26);
        check("ro_en_cycles_20", ro_cnt, 24);
        tick();
        check("done_width_20", DONE, 0);

        // Zero-length gate.
        start_run(0, 0, 0, 0, 0, 0);
        wait_done(0, 10);
        check("zero_gate_ro_en_cycles", ro_cnt, 0);
        check("zero_gate_busy_cycles", busy_cnt, 0);

        // 4-bit counter saturates with 50 edges in the window.
        ro_half = 20;
        repeat (20) tick();
        start_run(1, 200, 15, 0, 1, 0);
        wait_done(1, 260);

        // START held high for the whole run while GATE_LEN wanders; result 0 with RO low.
        ro_half = 0;
        repeat (30) tick();
        start_run(1, 50, 0, 0, 0, 1);
        d0 = done4_cnt;
        held_bad = 0;
        for (int i = 0; i < 120 && done4_cnt == d0; i++) begin
            GATE_LEN4 = 16'($urandom_range(1, 255));
            tick();
            if (done4_cnt == d0 && (COUNT4 !== 4'd15 || OVF4 !== 1'b1)) held_bad++;
        end
        check("held_result_bad_cycles", held_bad, 0);
        check("repulse_done_seen", done4_cnt - d0, 1);
        tick();
        START4 = 1'b0;
        repeat (70) tick();
        check("repulse_single_done", done4_cnt - d0, 1);
        check("repulse_busy4_after", BUSY4, 0);
        check("repulse_ro_en4_after", RO_EN4, 0);

        check("scoreboard_empty", q.size(), 0);
        check("scoreboard4_empty", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter GATE_W, default 16, width of gate-length input (CLK cycles).
REQ-002 SHALL have parameter CNT_W, default 16, width of edge-count result.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port START  input  1  measurement request, sampled in IDLE only.
REQ-007 SHALL have port GATE_LEN  input  GATE_W  gate window length in CLK cycles, sampled with START.
REQ-008 SHALL have port RO_IN  input  1  ring-oscillator output (asynchronous to CLK).
REQ-009 SHALL have port RO_EN  output  1  oscillator enable, drives the oscillator's enable inputs.
REQ-010 SHALL have port BUSY  output  1  measurement in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port COUNT  output  CNT_W  rising edges of RO_IN counted in the last gate window.
REQ-013 SHALL have port OVF  output  1  last measurement saturated.

Function
REQ-014 SHALL synchronise RO_IN through two flops, then detect rising edges with a third flop; max RO_IN frequency is CLK/4.
REQ-015 SHALL implement states IDLE, SETTLE, GATE, DRAIN, FIN.
REQ-016 IDLE: START=1 and GATE_LEN!=0 -> SETTLE; latch GATE_LEN, clear internal count and OVF accumulator.
REQ-017 IDLE: START=1 and GATE_LEN=0 -> FIN directly; result COUNT=0, OVF=0; RO_EN never asserted.
REQ-018 SETTLE SHALL last exactly 4 cycles; RO_EN=1; detected edges ignored.
REQ-019 GATE SHALL last exactly latched-GATE_LEN cycles; RO_EN=1; each detected edge increments the internal count.
REQ-020 Internal count SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets the OVF accumulator.
REQ-021 DRAIN SHALL last exactly 2 cycles; RO_EN=0; edges ignored.
REQ-022 FIN SHALL last 1 cycle: DONE=1, COUNT and OVF load from internal count/accumulator, then -> IDLE.
REQ-023 COUNT and OVF SHALL hold their last result at all other times, including throughout a new measurement.
REQ-024 BUSY SHALL be 1 in SETTLE, GATE, DRAIN; 0 in IDLE and FIN.
REQ-025 DONE SHALL assert exactly GATE_LEN+7 cycles after the CLK edge that samples START (GATE_LEN!=0), and 1 cycle after for GATE_LEN=0.
REQ-026 START SHALL be ignored in every state other than IDLE, including FIN; no queuing.
REQ-027 GATE_LEN changes after the sampling edge SHALL not affect the running measurement.
REQ-028 RO_EN SHALL be a registered output, glitch-free.

Reset
REQ-029 RST_N=0 SHALL immediately force state IDLE, RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0, synchroniser and edge flops to 0, internal count to 0.
REQ-030 Reset asserted mid-measurement SHALL abort it with no DONE pulse; first START after release SHALL begin a fresh measurement.

Verification
REQ-031 RO_IN period 10 CLK (5 high/5 low), GATE_LEN=100, START pulse -> DONE at START+107, COUNT=10 (+/-1 phase-dependent), OVF=0, RO_EN high exactly 104 cycles.
REQ-032 RO_IN held 0, GATE_LEN=20 -> DONE at START+27, COUNT=0, BUSY high 26 cycles, DONE high 1 cycle.
REQ-033 GATE_LEN=0, START -> DONE next cycle, COUNT=0, OVF=0, RO_EN and BUSY remain 0.
REQ-034 CNT_W=4, RO_IN period 4 CLK, GATE_LEN=200 -> COUNT=15, OVF=1; following run with RO_IN held 0 -> COUNT=0, OVF=0.
REQ-035 START re-pulsed every cycle during a GATE_LEN=50 run -> exactly one DONE at START+57; previous COUNT held until then.
REQ-036 RST_N pulsed low during GATE -> RO_EN, BUSY, COUNT, OVF drop to 0 without waiting for CLK; no DONE; next START completes normally.
